button_press_classifier: RTL

//  Front end for the three clock/alarm push-buttons. It synchronises and debounces b1..b3,

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_channel.sv | 142 ++++++++++++++
 rtl/button_press_classifier.sv | 69 ++++++
 3 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared definitions for the push-button front end: the per-channel FSM state
//   codes and the default debounce / long-press timing constants (50 MHz clock).
//   No ports.
// -----------------------------------------------------------------------------
package btn_pkg;

  // Per-channel classifier states (3-bit code).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DEB_PRESS = 3'd1;
  localparam logic [2:0] ST_HELD      = 3'd2;
  localparam logic [2:0] ST_LONG_DONE = 3'd3;
  localparam logic [2:0] ST_DEB_REL   = 3'd4;

  // 10 ms debounce and 1 s long-press threshold at 50 MHz.
  localparam int DEB_CYCLES  = 500000;
  localparam int LONG_CYCLES = 50000000;
  localparam int CNT_W       = 26;

endpackage

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
//   One push-button channel: two-flop synchroniser, debounce of press and
//   release, and short / long press classification.
// Ports
//   clock  in   system clock, all logic on posedge
//   reset  in   synchronous, active-high
//   b_raw  in   raw asynchronous button level, 1 = pressed
//   lung   out  one-cycle pulse when the debounced hold reaches LONG_CYCLES
//   scurt  out  one-cycle pulse when a press released before becoming long
//               finishes its release debounce
// -----------------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES  = btn_pkg::DEB_CYCLES,
  parameter int LONG_CYCLES = btn_pkg::LONG_CYCLES,
  parameter int CNT_W       = btn_pkg::CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic b_raw,
  output logic lung,
  output logic scurt
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             sync_1;
  logic             b_s;
  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] deb_next;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_next;
  logic             is_short;
  logic             short_next;
  logic             lung_next;
  logic             scurt_next;

  // State register: synchroniser, FSM state, counters, flag and the
  // registered output pulses.
  // NOTE: every flop here is written with <= so all of them sample the values
  // from before the edge; blocking = would let b_s see this cycle's sync_1.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1   <= 1'b0;
      b_s      <= 1'b0;
      state    <= ST_IDLE;
      deb_cnt  <= '0;
      hold_cnt <= '0;
      is_short <= 1'b0;
      lung     <= 1'b0;
      scurt    <= 1'b0;
    end else begin
      sync_1   <= b_raw;
      b_s      <= sync_1;
      state    <= state_next;
      deb_cnt  <= deb_next;
      hold_cnt <= hold_next;
      is_short <= short_next;
      lung     <= lung_next;
      scurt    <= scurt_next;
    end
  end

  // Next-state logic. Counters hold at their terminal value rather than
  // wrapping; hold_cnt is left untouched while a release is being debounced so
  // a bounce resumes the hold where it stopped.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is
    // inferred for the branches that leave a value unchanged.
    state_next = state;
    deb_next   = deb_cnt;
    hold_next  = hold_cnt;
    short_next = is_short;
    case (state)
      ST_IDLE: begin
        if (b_s) begin
          state_next = ST_DEB_PRESS;
          deb_next   = '0;
        end
      end
      ST_DEB_PRESS: begin
        if (!b_s) begin
          state_next = ST_IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = ST_HELD;
          hold_next  = '0;
          short_next = 1'b1;
        end else begin
          deb_next = deb_cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!b_s) begin
          state_next = ST_DEB_REL;
          deb_next   = '0;
        end else if (hold_cnt == LONG_LAST) begin
          state_next = ST_LONG_DONE;
          short_next = 1'b0;
        end else begin
          hold_next = hold_cnt + CNT_ONE;
        end
      end
      ST_LONG_DONE: begin
        if (!b_s) begin
          state_next = ST_DEB_REL;
          deb_next   = '0;
        end
      end
      ST_DEB_REL: begin
        if (b_s) begin
          state_next = is_short ? ST_HELD : ST_LONG_DONE;
        end else if (deb_cnt == DEB_LAST) begin
          state_next = ST_IDLE;
        end else begin
          deb_next = deb_cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output decode: the pulses are computed here and registered above, so they
  // appear in the cycle after the triggering transition.
  always_comb begin
    lung_next  = 1'b0;
    scurt_next = 1'b0;
    case (state)
      ST_HELD:    lung_next  = b_s && (hold_cnt == LONG_LAST);
      ST_DEB_REL: scurt_next = !b_s && (deb_cnt == DEB_LAST) && is_short;
      default: ;
    endcase
  end

endmodule

// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
//   Front end for the three clock/alarm push-buttons. Each button gets its own
//   independent btn_channel; outputs from different channels may pulse in the
//   same cycle and no priority is applied here.
// Ports
//   clock             in   system clock, all logic on posedge
//   reset             in   synchronous, active-high
//   b1..b3            in   raw asynchronous button levels, 1 = pressed
//   lung_1..lung_3    out  one-cycle pulse: long press detected on button N
//   scurt_1..scurt_3  out  one-cycle pulse: short press completed on button N
// -----------------------------------------------------------------------------
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES  = btn_pkg::DEB_CYCLES,
  parameter int LONG_CYCLES = btn_pkg::LONG_CYCLES,
  parameter int CNT_W       = btn_pkg::CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic b1,
  input  logic b2,
  input  logic b3,
  output logic lung_1,
  output logic lung_2,
  output logic lung_3,
  output logic scurt_1,
  output logic scurt_2,
  output logic scurt_3
);

  btn_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ch1 (
    .clock(clock),
    .reset(reset),
    .b_raw(b1),
    .lung (lung_1),
    .scurt(scurt_1)
  );

  btn_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ch2 (
    .clock(clock),
    .reset(reset),
    .b_raw(b2),
    .lung (lung_2),
    .scurt(scurt_2)
  );

  btn_channel #(
    .DEB_CYCLES (DEB_CYCLES),
    .LONG_CYCLES(LONG_CYCLES),
    .CNT_W      (CNT_W)
  ) u_ch3 (
    .clock(clock),
    .reset(reset),
    .b_raw(b3),
    .lung (lung_3),
    .scurt(scurt_3)
  );

endmodule
